// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - requester and adder_subtractor signals of addsub_arbiter
interface addsub_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             sub0;
   logic             sub1;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic [WIDTH-1:0] result;
   logic             result_carry;
   logic             busy;
   logic [WIDTH-1:0] ext_a;
   logic [WIDTH-1:0] ext_b;
   logic             ext_signal;
   logic [WIDTH-1:0] ext_sum;
   logic             ext_carry;

   // slave: the arbiter; master: the clients plus the shared adder_subtractor
   modport slave (
      input  req0, req1, a0, b0, a1, b1, sub0, sub1, ext_sum, ext_carry,
      output gnt0, gnt1, done0, done1, result, result_carry, busy,
             ext_a, ext_b, ext_signal
   );

   modport master (
      output req0, req1, a0, b0, a1, b1, sub0, sub1, ext_sum, ext_carry,
      input  gnt0, gnt1, done0, done1, result, result_carry, busy,
             ext_a, ext_b, ext_signal
   );
endinterface

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin sharing of one adder_subtractor between two requesters
module addsub_arbiter #(
   parameter int WIDTH = 4
) (
   input logic              clk,
   input logic              reset,
   addsub_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   state_t           state_d;
   logic             owner_q;
   logic             last_owner_q;
   logic             winner;
   logic             any_req;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic             op_sub_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic             busy;

   assign any_req = bus.req0 | bus.req1;
   // A tie goes to whoever was not served last; a lone request always wins.
   assign winner  = (bus.req0 && bus.req1) ? ~last_owner_q : bus.req1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      done0   = 1'b0;
      done1   = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) state_d = BUSY;
         end
         BUSY: begin
            gnt0    = ~owner_q;
            gnt1    = owner_q;
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done0   = ~owner_q;
            done1   = owner_q;
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_sub_q     <= 1'b0;
         result_q     <= '0;
         carry_q      <= 1'b0;
      end else begin
         if (state_q == IDLE && any_req) begin
            owner_q  <= winner;
            op_a_q   <= winner ? bus.a1 : bus.a0;
            op_b_q   <= winner ? bus.b1 : bus.b0;
            op_sub_q <= winner ? bus.sub1 : bus.sub0;
         end
         if (state_q == BUSY) begin
            result_q <= bus.ext_sum;
            carry_q  <= bus.ext_carry;
         end
         if (state_q == DONE) begin
            last_owner_q <= owner_q;
         end
      end
   end

   assign bus.gnt0         = gnt0;
   assign bus.gnt1         = gnt1;
   assign bus.done0        = done0;
   assign bus.done1        = done1;
   assign bus.busy         = busy;
   assign bus.result       = result_q;
   assign bus.result_carry = carry_q;
   assign bus.ext_a        = op_a_q;
   assign bus.ext_b        = op_b_q;
   assign bus.ext_signal   = op_sub_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed bench for addsub_arbiter with a behavioural adder_subtractor
module tb_addsub_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   tests  = 0;
   int   failed = 0;

   addsub_arbiter_if #(.WIDTH(4)) bus ();

   addsub_arbiter #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Shared adder_subtractor: subtract is a + ~b + 1, carry out is bit 4.
   logic [4:0] full;
   assign full = bus.ext_signal ? ({1'b0, bus.ext_a} + {1'b0, ~bus.ext_b} + 5'd1)
                                : ({1'b0, bus.ext_a} + {1'b0, bus.ext_b});
   assign bus.ext_sum   = full[3:0];
   assign bus.ext_carry = full[4];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Runs one grant with req already high; drop selects whether the owner releases req.
   task automatic serve(input string tag, input logic who, input logic [3:0] exp_res,
                        input logic exp_c, input logic drop);
      cycle();
      chk({tag, " gnt0"}, bus.gnt0, who ? 8'd0 : 8'd1);
      chk({tag, " gnt1"}, bus.gnt1, who ? 8'd1 : 8'd0);
      cycle();
      chk({tag, " done0"}, bus.done0, who ? 8'd0 : 8'd1);
      chk({tag, " done1"}, bus.done1, who ? 8'd1 : 8'd0);
      chk({tag, " result"}, bus.result, exp_res);
      chk({tag, " carry"}, bus.result_carry, exp_c);
      if (drop) begin
         if (who) bus.req1 = 1'b0;
         else     bus.req0 = 1'b0;
      end
      cycle();
      chk({tag, " idle done"}, {bus.done0, bus.done1}, 8'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.sub0 = 0; bus.sub1 = 0;
      bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
      cycle();
      cycle();
      reset = 1'b0;
      cycle();
      chk("rst busy", bus.busy, 8'd0);
      chk("rst gnt", {bus.gnt0, bus.gnt1}, 8'd0);
      chk("rst done", {bus.done0, bus.done1}, 8'd0);
      chk("rst result", {bus.result_carry, bus.result}, 8'd0);
      chk("rst ext", {bus.ext_signal, bus.ext_a, bus.ext_b}, 8'd0);

      // 4 + 5, operands changed after grant must not matter
      bus.a0 = 4; bus.b0 = 5; bus.sub0 = 0; bus.req0 = 1;
      cycle();
      chk("add gnt0", bus.gnt0, 8'd1);
      chk("add busy", bus.busy, 8'd1);
      chk("add ext_a", bus.ext_a, 8'd4);
      chk("add ext_b", bus.ext_b, 8'd5);
      chk("add ext_signal", bus.ext_signal, 8'd0);
      bus.a0 = 15; bus.b0 = 15; bus.sub0 = 1;
      cycle();
      chk("add done0", bus.done0, 8'd1);
      chk("add done1", bus.done1, 8'd0);
      chk("add result", bus.result, 8'h9);
      chk("add carry", bus.result_carry, 8'd0);
      chk("add busy done", bus.busy, 8'd1);
      bus.req0 = 0;
      cycle();
      chk("add idle busy", bus.busy, 8'd0);
      chk("add hold result", bus.result, 8'h9);
      chk("add hold ext_a", bus.ext_a, 8'd4);

      // 10 - 5 on requester 1
      bus.a1 = 10; bus.b1 = 5; bus.sub1 = 1; bus.req1 = 1;
      cycle();
      chk("sub ext_signal", bus.ext_signal, 8'd1);
      chk("sub gnt1", bus.gnt1, 8'd1);
      cycle();
      chk("sub done1", bus.done1, 8'd1);
      chk("sub result", bus.result, 8'h5);
      chk("sub carry", bus.result_carry, 8'd1);
      bus.req1 = 0;
      cycle();

      bus.a0 = 3; bus.b0 = 4; bus.sub0 = 1; bus.req0 = 1;
      serve("3-4", 1'b0, 4'hF, 1'b0, 1'b1);
      bus.a0 = 7; bus.b0 = 8; bus.sub0 = 1; bus.req0 = 1;
      serve("7-8", 1'b0, 4'hF, 1'b0, 1'b1);

      // Tie after reset: requester 0 first, requester 1 three cycles later
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      bus.a0 = 1; bus.b0 = 2; bus.sub0 = 0;
      bus.a1 = 9; bus.b1 = 9; bus.sub1 = 0;
      bus.req0 = 1; bus.req1 = 1;
      serve("tie1 first", 1'b0, 4'h3, 1'b0, 1'b1);
      serve("tie1 second", 1'b1, 4'h2, 1'b1, 1'b1);

      // Serving 0 alone makes 1 the tie winner next
      bus.req0 = 1;
      serve("solo0", 1'b0, 4'h3, 1'b0, 1'b1);
      bus.req0 = 1; bus.req1 = 1;
      serve("tie2 first", 1'b1, 4'h2, 1'b1, 1'b1);
      serve("tie2 second", 1'b0, 4'h3, 1'b0, 1'b1);

      // Reset during BUSY: immediate reset values, no done, last_owner back to 1
      bus.a0 = 6; bus.b0 = 1; bus.sub0 = 0; bus.req0 = 1;
      cycle();
      chk("abort gnt0", bus.gnt0, 8'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort busy", bus.busy, 8'd0);
      chk("abort gnt", {bus.gnt0, bus.gnt1}, 8'd0);
      chk("abort result", {bus.result_carry, bus.result}, 8'd0);
      chk("abort ext", {bus.ext_signal, bus.ext_a, bus.ext_b}, 8'd0);
      cycle();
      chk("abort no done", {bus.done0, bus.done1}, 8'd0);
      reset = 1'b0;

      // Both held continuously: grants alternate 0,1,0,1 starting with 0
      bus.a0 = 2; bus.b0 = 3; bus.sub0 = 0;
      bus.a1 = 5; bus.b1 = 7; bus.sub1 = 1;
      bus.req0 = 1; bus.req1 = 1;
      serve("rr 0a", 1'b0, 4'h5, 1'b0, 1'b0);
      serve("rr 1a", 1'b1, 4'hE, 1'b0, 1'b0);
      serve("rr 0b", 1'b0, 4'h5, 1'b0, 1'b0);
      serve("rr 1b", 1'b1, 4'hE, 1'b0, 1'b1);
      bus.req0 = 0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
